// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble binary-to-BCD converter, one input bit per clock
module bin2bcd #(
    parameter int BIN_W = 20,
    parameter int NDIG  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                ready,
    output logic                done_tick,
    output logic [4*NDIG-1:0]   bcd
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [1:0] IDLE = 2'd0, OP = 2'd1, DONE = 2'd2;
    logic [1:0]        state;
    logic [BIN_W-1:0]  sreg;
    logic [4*NDIG-1:0] dig, adj;
    logic [CW-1:0]     cnt;
    genvar i;
    generate
        for (i = 0; i < NDIG; i++) begin : g_adj
            assign adj[4*i+:4] = (dig[4*i+:4] >= 4'd5) ? dig[4*i+:4] + 4'd3 : dig[4*i+:4];
        end
    endgenerate
    assign ready     = (state == IDLE);
    assign done_tick = (state == DONE);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            dig   <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sreg  <= bin;
                    dig   <= '0;
                    cnt   <= CW'(BIN_W);
                    state <= OP;
                end
                OP: begin
                    // {digits, operand} rotates; the top digit MSB is always 0 so the refill is harmless
                    {dig, sreg} <= {adj[4*NDIG-2:0], sreg, adj[4*NDIG-1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bcd   <= {adj[4*NDIG-2:0], sreg[BIN_W-1]};
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: directed and random checks of bin2bcd latency, strobe, throughput and reset abort
module tb_bin2bcd;
    logic        clk = 0, reset = 1, start = 0;
    logic [19:0] bin = '0;
    logic        ready, done_tick;
    logic [27:0] bcd;
    int n = 0, errs = 0;

    bin2bcd dut (.clk(clk), .reset(reset), .start(start), .bin(bin),
                 .ready(ready), .done_tick(done_tick), .bcd(bcd));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
        n++;
        assert (o === x) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] dec(input logic [19:0] v);
        int t;
        logic [27:0] e;
        t = int'(v);
        e = '0;
        for (int d = 0; d < 7; d++) begin
            e[4*d+:4] = 4'(t % 10);
            t = t / 10;
        end
        return e;
    endfunction

    task automatic conv(input string tag, input logic [19:0] v, input logic [27:0] e);
        logic [27:0] prev;
        prev = bcd;
        chk({tag, " ready"}, 64'(ready), 64'd1);
        bin = v;
        start = 1;
        step;
        start = 0;
        bin = ~v;
        for (int k = 0; k < 20; k++) begin
            chk({tag, " busy"}, {done_tick, ready, bcd}, {2'b00, prev});
            step;
        end
        chk({tag, " done"}, {done_tick, ready, bcd}, {2'b10, e});
        step;
        chk({tag, " idle"}, {done_tick, ready, bcd}, {2'b01, e});
    endtask

    initial begin
        logic [27:0] prev, b;
        logic [19:0] v;
        logic d, r;
        step;
        step;
        chk("reset", {done_tick, ready, bcd}, {2'b01, 28'h0});
        reset = 0;
        step;
        conv("699999", 20'd699999, 28'h0699999);
        conv("zero", 20'd0, 28'h0000000);
        conv("allones", 20'd1048575, 28'h1048575);
        conv("999999", 20'd999999, 28'h0999999);
        conv("1000000", 20'd1000000, 28'h1000000);
        conv("one", 20'd1, 28'h0000001);

        prev = bcd;
        bin = 20'd500000;
        start = 1;
        step;
        bin = 20'd12345;
        for (int k = 0; k <= 43; k++) begin
            d = (k == 20 || k == 42);
            r = (k == 21 || k == 43);
            b = (k < 20) ? prev : (k < 42) ? 28'h0500000 : 28'h0012345;
            chk("backtoback", {done_tick, ready, bcd}, {d, r, b});
            if (k == 22) start = 0;
            step;
        end

        bin = 20'd699999;
        start = 1;
        step;
        start = 0;
        for (int k = 0; k < 9; k++) step;
        chk("abort pre", {done_tick, ready, bcd}, {2'b00, 28'h0012345});
        reset = 1;
        step;
        reset = 0;
        chk("abort reset", {done_tick, ready, bcd}, {2'b01, 28'h0});
        for (int k = 0; k < 25; k++) begin
            chk("abort quiet", {done_tick, ready, bcd}, {2'b01, 28'h0});
            step;
        end
        conv("after abort", 20'd699999, 28'h0699999);

        for (int k = 0; k < 200; k++) begin
            v = 20'($urandom_range(0, 1048575));
            conv("random", v, dec(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/bin2bcd.md
Name: bin2bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Accepts an unsigned binary word on a start pulse or level.
- Produces packed BCD digits plus a one-cycle completion strobe.
- Used ahead of decimal display/formatting logic; trades latency (BIN_W+2 cycles per conversion) for small area.

Parameters:
- BIN_W, 20: width of the binary input in bits.
- NDIG, 7: number of BCD output digits. Must satisfy 10^NDIG > 2^BIN_W−1. The default covers 0..1048575.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary operand; sampled on the edge that accepts start.
- ready  output  1  high while in IDLE (able to accept start).
- done_tick  output  1  single-cycle strobe: conversion complete, bcd valid.
- bcd  output  4*NDIG  packed BCD result. Digit 0 (units) in [3:0], digit k in [4k+3:4k].

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, bcd=0, done_tick=0, ready=1, all working registers cleared. Reset mid-conversion aborts it; no done_tick is issued for the aborted conversion.
- FSM states and transitions:
  - IDLE: ready=1. On start=1, latch bin into the shift register, clear the working BCD digits, load the bit counter with BIN_W, go to OP. On start=0, remain in IDLE.
  - OP: each cycle, first every working digit ≥5 gets +3 (4-bit, no carry between digits). Then shift {digits, binreg} left by one: the binreg MSB enters digit 0 bit 0, and each digit's MSB enters the next digit's bit 0. Decrement the counter. When the counter reaches 0 after the BIN_W-th shift, go to DONE.
  - DONE: done_tick=1 (Moore output, exactly one cycle). The working digits are copied into the bcd output register on entry to DONE, i.e. on the same edge as the final shift. Next state is IDLE.
- Latency: start accepted at edge 0. Shifts occur at edges 1..BIN_W; bcd is valid and done_tick is high from edge BIN_W until edge BIN_W+1. ready returns high at edge BIN_W+1.
- Throughput: with start held high continuously, a new conversion is accepted at edge BIN_W+2. done_tick then pulses every BIN_W+2 cycles (22 with default BIN_W).
- bcd holds its last result until the next completion. It does not change during a conversion, is not cleared on start, and is cleared only by reset.
- start and bin changes while not in IDLE are ignored. The operand is fixed at the accept edge.
- All outputs are registered or state-decoded, with no combinational path from inputs to outputs.
- Each output digit is always in 0..9. Leading digits are zero (e.g. 699999 → digit 6 = 0).

Test Plan:
- Reset then bin=699999, start=1 → done_tick single pulse 21 edges after reset release + 1 (edge 20 after accept); bcd=28'h0699999; ready low during OP/DONE.
- bin=0 → after 20 shifts bcd=28'h0000000, done_tick pulses once.
- bin=1048575 (all ones) → bcd=28'h1048575. Also bin=999999 → 28'h0999999, and bin=1000000 → 28'h1000000 (digit-carry boundary).
- start held high, bin changed to 12345 mid-conversion → first result reflects the accepted operand only. done_tick repeats every 22 cycles; the next result is 28'h0012345.
- reset asserted at the 10th OP cycle → next edge: IDLE, bcd=0, done_tick never asserted for the aborted conversion. A fresh start then completes normally.
- Randomised bin over 200 conversions → bcd equals the decimal digits of bin. done_tick is exactly one cycle wide, and bcd is stable between completions.
